// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, types and address helper for the plot sink.
//   SCREEN_W/SCREEN_H : visible geometry (160x120)
//   FB_DEPTH          : framebuffer entries (19200)
//   colour_t, fb_addr_t, coord_x_t, coord_y_t, clr_state_t
//   fb_addr()         : y*160 + x built from shifts, no multiplier
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_DEPTH = SCREEN_W * SCREEN_H;

  typedef logic [2:0]  colour_t;
  typedef logic [14:0] fb_addr_t;
  typedef logic [7:0]  coord_x_t;
  typedef logic [6:0]  coord_y_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // y*160 = y*128 + y*32
  function automatic fb_addr_t fb_addr(input coord_x_t x, input coord_y_t y);
    fb_addr_t w_y;
    w_y = fb_addr_t'(y);
    return (w_y << 7) + (w_y << 5) + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/vga_plot_sink_if.sv
// vga_plot_sink_if: pixel-plot bus from the shape drawers to the sink.
//   vga_x (8), vga_y (7), vga_colour (3), vga_plot (strobe, one pixel/cycle)
//   master : drawer side (drives all signals)
//   slave  : sink side   (samples all signals)
interface vga_plot_sink_if;
  import vga_pkg::*;

  coord_x_t vga_x;
  coord_y_t vga_y;
  colour_t  vga_colour;
  logic     vga_plot;

  modport master (output vga_x, vga_y, vga_colour, vga_plot);
  modport slave  (input  vga_x, vga_y, vga_colour, vga_plot);

endinterface

// File: rtl/fb_ram.sv
// fb_ram: 19200x3 simple dual-port framebuffer, one write port and one
// registered read port, read-before-write on address collision, no reset.
//   clk     : clock
//   i_we    : write enable, i_waddr / i_wdata : write address / data
//   i_re    : read enable,  i_raddr : read address
//   o_rdata : read data, valid the cycle after i_re
module fb_ram
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     i_we,
  input  fb_addr_t i_waddr,
  input  colour_t  i_wdata,
  input  logic     i_re,
  input  fb_addr_t i_raddr,
  output colour_t  o_rdata
);

  colour_t r_mem [FB_DEPTH];
  colour_t r_rdata;

  // Both ports in one block so a same-address read samples the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: commits in-range plots into a 160x120x3 framebuffer,
// provides a bulk clear engine and a raster-order scanout stream.
//   clk, rst            : clock, synchronous active-high reset
//   plot                : plot bus (slave modport)
//   clear_start/colour  : start a fill with the given colour
//   clear_busy/done     : fill in progress / one-cycle completion pulse
//   scan_en             : advance scanout one pixel
//   pix_x/y/colour      : scanout pixel, qualified by pix_valid
//   frame_start         : pix_valid for pixel (0,0)
// Optional: define VGA_PLOT_SINK_STATS_EN to add saturating 16-bit
// plot_count / drop_count outputs.
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             rst,
  vga_plot_sink_if.slave   plot,
  input  logic             clear_start,
  input  colour_t          clear_colour,
  output logic             clear_busy,
  output logic             clear_done,
  input  logic             scan_en,
  output coord_x_t         pix_x,
  output coord_y_t         pix_y,
  output colour_t          pix_colour,
  output logic             pix_valid,
  output logic             frame_start
`ifdef VGA_PLOT_SINK_STATS_EN
  ,
  output logic [15:0]      plot_count,
  output logic [15:0]      drop_count
`endif
);

  clr_state_t r_state, w_state_next;
  fb_addr_t   r_fill_addr;
  colour_t    r_fill_colour;
  logic       r_clear_done;
  logic       w_fill_start, w_fill_last, w_clear_last;

  logic       w_in_range, w_plot_commit;
  fb_addr_t   w_plot_addr;

  logic       w_we;
  fb_addr_t   w_waddr;
  colour_t    w_wdata;
  colour_t    w_rd_data;

  coord_x_t   r_sx, r_s1_x, r_pix_x;
  coord_y_t   r_sy, r_s1_y, r_pix_y;
  fb_addr_t   r_rd_addr;
  logic       r_s1_valid, r_pix_valid;
  logic       w_sx_last, w_sy_last;

  // Plot path
  assign w_in_range    = (32'(plot.vga_x) < SCREEN_W) && (32'(plot.vga_y) < SCREEN_H);
  assign w_plot_commit = plot.vga_plot && w_in_range && (r_state == ST_IDLE);
  assign w_plot_addr   = fb_addr(plot.vga_x, plot.vga_y);

  // Clear FSM
  assign w_fill_last = (r_fill_addr == fb_addr_t'(SCREEN_W * SCREEN_H - 1));

  always_comb begin
    w_state_next = r_state;
    w_fill_start = 1'b0;
    w_clear_last = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_next = ST_CLEAR;
          w_fill_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_fill_last) begin
          w_state_next = ST_IDLE;
          w_clear_last = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_fill_addr   <= '0;
      r_fill_colour <= '0;
      r_clear_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clear_done <= w_clear_last;
      if (w_fill_start) begin
        r_fill_addr   <= '0;
        r_fill_colour <= clear_colour;
      end else if (r_state == ST_CLEAR) begin
        r_fill_addr <= r_fill_addr + 1'b1;
      end
    end
  end

  assign clear_busy = (r_state == ST_CLEAR);
  assign clear_done = r_clear_done;

  // Write-port mux: the fill owns the port for its whole duration
  assign w_we    = clear_busy || w_plot_commit;
  assign w_waddr = clear_busy ? r_fill_addr   : w_plot_addr;
  assign w_wdata = clear_busy ? r_fill_colour : plot.vga_colour;

  // Scanout: counters + address stage, RAM read is the second stage
  assign w_sx_last = (r_sx == 8'(SCREEN_W - 1));
  assign w_sy_last = (r_sy == 7'(SCREEN_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx        <= '0;
      r_sy        <= '0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_rd_addr   <= '0;
      r_s1_valid  <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_valid <= 1'b0;
    end else begin
      r_s1_valid <= scan_en;
      if (scan_en) begin
        r_rd_addr <= fb_addr(r_sx, r_sy);
        r_s1_x    <= r_sx;
        r_s1_y    <= r_sy;
        if (w_sx_last) begin
          r_sx <= '0;
          r_sy <= w_sy_last ? '0 : r_sy + 1'b1;
        end else begin
          r_sx <= r_sx + 1'b1;
        end
      end
      r_pix_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_pix_x <= r_s1_x;
        r_pix_y <= r_s1_y;
      end
    end
  end

  fb_ram u_fb_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (r_s1_valid),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rd_data)
  );

  // RAM output register has no reset; mask it so idle/reset output is 0
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_valid   = r_pix_valid;
  assign pix_colour  = r_pix_valid ? w_rd_data : '0;
  assign frame_start = r_pix_valid && (r_pix_x == '0) && (r_pix_y == '0);

`ifdef VGA_PLOT_SINK_STATS_EN
  logic        w_plot_drop;
  logic [15:0] r_plot_count, r_drop_count;

  assign w_plot_drop = plot.vga_plot && !w_plot_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_plot_count <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_plot_commit && (r_plot_count != '1)) r_plot_count <= r_plot_count + 1'b1;
      if (w_plot_drop   && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign plot_count = r_plot_count;
  assign drop_count = r_drop_count;
`endif

endmodule
